// File: rtl/p0_serial_tx.sv
// Traces every change of the P0 word onto a UART line as two 8N1 frames, low byte first, via a small FIFO.
// Latency: change seen at edge k, START at edge k+1 when idle; no backpressure, a push into a full FIFO without pop is dropped and flagged.
module p0_serial_tx #(
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             p0_data,
    input  logic                          cap_en,
    input  logic                          ovf_clr,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [DATA_W-1:0] last_seen_q, last_seen_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              byte_sel_q, byte_sel_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              tx_q, tx_d, busy_q, busy_d;

    logic push, pop, full, push_ok, timer_last;

    assign full       = (count_q == FULL_CNT);
    assign push       = cap_en && (p0_data != last_seen_q);
    assign timer_last = (timer_q == T_LAST);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_last ? '0 : timer_q + TW'(1);
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        word_d     = word_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    word_d     = mem_q[rd_ptr_q];
                    byte_sel_d = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (timer_last) begin
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (timer_last) begin
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            default: begin
                // Low-byte stop runs straight into the high-byte start bit.
                if (timer_last) begin
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = S_START;
                    end else begin
                        state_d    = S_IDLE;
                    end
                end
            end
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = word_d[{byte_sel_d, bit_idx_d}];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        last_seen_d = p0_data;
        push_ok     = push && (!full || pop);
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = p0_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push && full && !pop) ovf_d = 1'b1;
        else if (ovf_clr)         ovf_d = 1'b0;
        else                      ovf_d = ovf_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_seen_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            byte_sel_q  <= 1'b0;
            word_q      <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            last_seen_q <= last_seen_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            byte_sel_q  <= byte_sel_d;
            word_q      <= word_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_p0_serial_tx.sv
// Bench for p0_serial_tx: directed scenarios plus random P0 traffic, checked against a cycle-level line model.
module tb_p0_serial_tx;
    localparam int C  = 4;
    localparam int FD = 4;
    localparam int WORD_CYC = 20 * C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] p0_data = 16'h0000;
    logic        cap_en = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        tx, busy, overflow;
    logic [2:0]  fifo_count;

    int checks = 0;
    int failures = 0;
    int words_seen = 0;
    bit chk_en = 0;

    // Reference model state: queued words, the word on the line and when it started.
    logic [15:0] m_q[$];
    logic [15:0] m_last = 16'h0000;
    logic [15:0] m_word = 16'h0000;
    logic        m_ovf = 1'b0;
    logic        m_active = 1'b0;
    int          m_cyc = 0;
    int          m_start = 0;
    int          m_next_pop = 0;

    p0_serial_tx #(.DATA_W(16), .FIFO_DEPTH(FD), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .p0_data(p0_data), .cap_en(cap_en), .ovf_clr(ovf_clr),
        .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic exp_tx();
        int o, s, pos;
        o = m_cyc - m_start;
        if (!m_active || o >= WORD_CYC) return 1'b1;
        s   = o / C;
        pos = s % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return m_word[(s / 10) * 8 + pos - 1];
    endfunction

    initial begin : model
        bit pop, push, full;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_last = 16'h0000; m_ovf = 1'b0; m_active = 1'b0;
                m_cyc = 0; m_next_pop = 0;
            end else begin
                m_cyc++;
                pop  = (m_q.size() > 0) && (m_cyc >= m_next_pop);
                full = (m_q.size() == FD);
                push = cap_en && (p0_data != m_last);
                if (pop) begin
                    m_word = m_q.pop_front();
                    m_start = m_cyc;
                    m_active = 1'b1;
                    m_next_pop = m_cyc + WORD_CYC + 1;
                end
                if (push && (!full || pop)) m_q.push_back(p0_data);
                if (push && full && !pop) m_ovf = 1'b1;
                else if (ovf_clr)         m_ovf = 1'b0;
                m_last = p0_data;
            end
        end
    end

    initial begin : monitor
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && prev_busy === 1'b0) words_seen++;
            prev_busy = busy;
            if (chk_en) begin
                chk("mon_tx", tx, exp_tx());
                chk("mon_busy", busy, m_active && (m_cyc - m_start) < WORD_CYC);
                chk("mon_count", fifo_count, m_q.size());
                chk("mon_ovf", overflow, m_ovf);
            end
        end
    end

    // Call with START just entered; returns one bit period after the second stop bit began.
    task automatic decode(output logic [15:0] w, output logic fr_ok);
        logic [19:0] b;
        step(C / 2);
        for (int s = 0; s < 20; s++) begin
            b[s] = tx;
            if (s < 19) step(C);
        end
        step(C - C / 2);
        w = {b[18:11], b[8:1]};
        fr_ok = !b[0] && b[9] && !b[10] && b[19];
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] w1, w2;
        logic ok1, ok2, found;
        int w0, r;

        // Reset state
        step(3);
        chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0); chk("rst_ovf", overflow, 0);
        rst = 1'b1;
        chk_en = 1;
        step(2);

        // Single word, frame timing and bit order
        p0_data = 16'hA55A; cap_en = 1'b1;
        step(1);
        chk("sw_push_count", fifo_count, 1); chk("sw_push_tx", tx, 1); chk("sw_push_busy", busy, 0);
        step(1);
        chk("sw_start_tx", tx, 0); chk("sw_start_busy", busy, 1); chk("sw_start_count", fifo_count, 0);
        decode(w1, ok1);
        chk("sw_frame", ok1, 1); chk("sw_lo", w1[7:0], 8'h5A); chk("sw_hi", w1[15:8], 8'hA5);
        chk("sw_end_busy", busy, 0); chk("sw_end_tx", tx, 1);
        step(3);

        // Asynchronous reset in the middle of a data bit
        p0_data = 16'h1234;
        step(2);
        step(14);
        chk("mr_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mr_tx", tx, 1); chk("mr_busy", busy, 0); chk("mr_count", fifo_count, 0);
        p0_data = 16'h0000;
        step(2);
        rst = 1'b1;
        step(40);
        chk("mr_after_tx", tx, 1); chk("mr_after_busy", busy, 0);

        // No duplicate pushes while a value is held; cap_en gating
        w0 = words_seen;
        p0_data = 16'h1234;
        step(1);
        chk("nd_first_count", fifo_count, 1);
        step(200);
        chk("nd_hold_words", words_seen - w0, 1);
        p0_data = 16'h1235;
        step(1);
        chk("nd_second_count", fifo_count, 1);
        step(100);
        chk("nd_second_words", words_seen - w0, 2);
        cap_en = 1'b0; p0_data = 16'h0001;
        step(3);
        chk("nd_dis_count", fifo_count, 0); chk("nd_dis_busy", busy, 0);
        cap_en = 1'b1;
        step(3);
        chk("nd_reen_count", fifo_count, 0); chk("nd_reen_busy", busy, 0);
        chk("nd_total_words", words_seen - w0, 2);

        // Overflow: five extra words while one transmits
        w0 = words_seen;
        p0_data = 16'h1111;
        step(2);
        for (int i = 2; i <= 6; i++) begin
            p0_data = 16'(i * 32'h1111);
            step(1);
        end
        chk("ov_count", fifo_count, 4); chk("ov_flag", overflow, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ov_clr", overflow, 0);
        step(5 * (WORD_CYC + 1) + 10);
        chk("ov_words", words_seen - w0, 5); chk("ov_drain", fifo_count, 0);

        // Push coinciding with the IDLE pop while full
        w0 = words_seen;
        p0_data = 16'h7001;
        step(2);
        for (int i = 2; i <= 5; i++) begin
            p0_data = 16'h7000 + 16'(i);
            step(1);
        end
        chk("fp_full", fifo_count, 4);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if (busy === 1'b0) found = 1'b1;
        end
        chk("fp_idle_found", found, 1);
        p0_data = 16'h7006;
        step(1);
        chk("fp_count", fifo_count, 4); chk("fp_ovf", overflow, 0); chk("fp_busy", busy, 1);
        step(5 * (WORD_CYC + 1) + 20);
        chk("fp_words", words_seen - w0, 6); chk("fp_drain", fifo_count, 0);

        // Back-to-back words with exactly one idle cycle
        p0_data = 16'h0000;
        step(1);
        p0_data = 16'hFFFF;
        step(1);
        chk("bb_start1", tx, 0);
        decode(w1, ok1);
        chk("bb_gap_tx", tx, 1); chk("bb_gap_busy", busy, 0);
        step(1);
        chk("bb_start2_tx", tx, 0); chk("bb_start2_busy", busy, 1);
        decode(w2, ok2);
        chk("bb_frame1", ok1, 1); chk("bb_word1", w1, 16'h0000);
        chk("bb_frame2", ok2, 1); chk("bb_word2", w2, 16'hFFFF);
        step(2);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                r = int'($urandom_range(0, 3));
                p0_data = 16'(r * 32'h1111);
            end
            cap_en  = ($urandom_range(0, 7) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            step(1);
        end
        cap_en = 1'b1; ovf_clr = 1'b0;
        step(6 * (WORD_CYC + 1));
        chk("rnd_drain_count", fifo_count, 0); chk("rnd_drain_busy", busy, 0); chk("rnd_drain_tx", tx, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("rnd_ovf_clr", overflow, 0);
        step(2);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/p0_serial_tx.md
Name: p0_serial_tx

Overview:
Downstream consumer of the microcontroller's P0 output port. It watches the 16-bit P0 register output for value changes and queues each new value in a small FIFO. Each queued word is serialised onto a single UART-style line as two 8N1 frames, low byte first. It gives the core a host-visible trace of every value written to P0, and the core needs no extra control signal to use it.

Parameters:
DATA_W, 16, width of the P0 word (must be 16; framing is fixed at two bytes)
FIFO_DEPTH, 4, number of queued words (power of two, minimum 2)
CLKS_PER_BIT, 16, clock cycles per serial bit (minimum 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
p0_data  input  16  P0 register output from the core
cap_en  input  1  1 = change detection pushes into the FIFO
ovf_clr  input  1  synchronous clear of the overflow flag
tx  output  1  serial line, idles high
busy  output  1  1 while the FSM is not in IDLE
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO
overflow  output  1  sticky flag: a word was dropped because the FIFO was full

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-frame):
  - Outputs: tx=1, busy=0, fifo_count=0, overflow=0.
  - Internal: FSM=IDLE, last_seen=16'h0000, FIFO pointers=0, bit timer=0.
  - Leaving reset mid-frame abandons the frame; tx stays high.
- Change detection, every rising edge:
  - last_seen <= p0_data, unconditionally.
  - push = cap_en && (p0_data != last_seen).
  - Holding a value produces no further pushes. A return to an earlier value is a change.
  - With cap_en=0, last_seen keeps tracking, so re-enabling does not push the stale value.
- FIFO:
  - Push writes p0_data at the tail.
  - Pop is asserted by the FSM in IDLE when fifo_count>0; it reads the head into the shift register.
  - Push and pop in the same cycle: both take effect and fifo_count is unchanged. This holds even when full, so the push is accepted.
  - Push when full with no pop: the word is dropped and overflow<=1.
  - overflow clears only on ovf_clr=1. If set and clear coincide, set wins.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP, plus byte_sel (0 = low byte, 1 = high byte).
  - IDLE: tx=1, busy=0. If fifo_count>0: pop, byte_sel<=0, timer<=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx = selected byte's bit[index], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_sel=0: set byte_sel<=1 and go to START with no idle gap.
    - If byte_sel=1: go to IDLE.
  - The timer counts 0..CLKS_PER_BIT-1. A state advances on the cycle the timer equals CLKS_PER_BIT-1.
- Timing:
  - One word occupies exactly 20*CLKS_PER_BIT cycles from START entry to STOP exit.
  - Back-to-back words have exactly one IDLE cycle (tx=1) between them.
  - Latency: p0_data changes before edge k → pushed at edge k → popped and START entered at edge k+1 → tx low from edge k+1, provided the FIFO was empty and the FSM idle.
- tx and busy are registered outputs.

Test Plan:
- Reset/idle: assert rst=0 mid-DATA with CLKS_PER_BIT=4 → tx=1, busy=0, fifo_count=0 immediately; after release tx stays 1 and no frame is sent.
- Single word: CLKS_PER_BIT=4, p0_data 0→16'hA55A with cap_en=1.
  - tx falls one edge after the push and the frame lasts 80 cycles.
  - Decoded bits: start, 0,1,0,1,1,0,1,0 (0x5A), stop, start, 1,0,1,0,0,1,0,1 (0xA5), stop.
  - Then IDLE with busy=0.
- No duplicates: hold 16'h1234 for 200 cycles → exactly one push. Change to 16'h1235 → a second push. Set cap_en=0 and change to 16'h0001 → no push; re-enable with the value held → no push.
- Overflow, FIFO_DEPTH=4:
  - While word 1 transmits, write 5 further distinct values → fifo_count reaches 4, overflow=1, and the 5th extra value never appears on tx.
  - Pulse ovf_clr → overflow=0.
- Full + pop coincident: with the FIFO full, time a new value on the exact cycle IDLE pops → word accepted, fifo_count stays 4, overflow stays 0.
- Back-to-back: queue 16'h0000 then 16'hFFFF → exactly one tx=1 IDLE cycle between the two 80-cycle words; the decoded words match in order.
